// File: rtl/sram_port_ctrl.sv
// Valid/ready front-end for port 0 of the 32x256 SRAM macro.
// Registers macro controls, tracks read latency and buffers read data in a credit-gated FIFO.
module sram_port_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_WMASKS-1:0] req_wmask,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  busy
);

   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(RSP_DEPTH);
   localparam logic [PTR_W+1:0] CREDIT_MAX = (PTR_W+2)'(RSP_DEPTH);

   logic [1:0]            rd_pipe;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W:0]        count;
   logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
   logic [PTR_W+1:0]      credit_sum;
   logic                  accept;
   logic                  push;
   logic                  pop;

   // Reads in flight are counted against FIFO space so a result always has a slot.
   assign credit_sum = {1'b0, count}
                     + {{(PTR_W+1){1'b0}}, rd_pipe[0]}
                     + {{(PTR_W+1){1'b0}}, rd_pipe[1]};
   assign req_ready  = rst_n && (credit_sum < CREDIT_MAX);
   assign accept     = req_valid && req_ready;
   assign push       = rd_pipe[1];
   assign pop        = rsp_valid && rsp_ready;
   assign rsp_valid  = (count != '0);
   assign rsp_rdata  = fifo_mem[rd_ptr];
   assign busy       = (rd_pipe != 2'b00) || (count != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
      end else if (accept) begin
         sram_csb0   <= 1'b0;
         sram_web0   <= ~req_we;
         sram_wmask0 <= req_we ? req_wmask : '0;
         sram_addr0  <= req_addr;
         sram_din0   <= req_wdata;
      end else begin
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_pipe <= 2'b00;
      end else begin
         rd_pipe <= {rd_pipe[0], accept && !req_we};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= sram_dout0;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && count == FULL_CNT));

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: macro model, reference memory with expected-response queue,
// directed vector table, hand-written latency/backpressure/reset sequences and random traffic.
module tb_sram_port_ctrl;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int NM = 4;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [NM-1:0] req_wmask = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          sram_csb0;
   logic          sram_web0;
   logic [NM-1:0] sram_wmask0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0;
   logic [DW-1:0] sram_dout0 = '0;
   logic          busy;

   logic rsp_ready_man = 1'b1;
   logic rnd_rdy = 1'b0;
   logic rnd_bit = 1'b0;
   assign rsp_ready = rnd_rdy ? rnd_bit : rsp_ready_man;

   always #5 clk = ~clk;

   sram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM), .RSP_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
      .busy(busy)
   );

   // Macro: latches controls at posedge, writes or reads on the following negedge.
   logic [DW-1:0] macro_mem [256];
   logic          lat_cs = 1'b0;
   logic          lat_we = 1'b0;
   logic [AW-1:0] lat_addr = '0;
   logic [NM-1:0] lat_mask = '0;
   logic [DW-1:0] lat_din = '0;

   always @(posedge clk) begin
      lat_cs   <= ~sram_csb0;
      lat_we   <= ~sram_web0;
      lat_addr <= sram_addr0;
      lat_mask <= sram_wmask0;
      lat_din  <= sram_din0;
      rnd_bit  <= 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (lat_cs) begin
         if (lat_we) begin
            for (int b = 0; b < NM; b++)
               if (lat_mask[b]) macro_mem[lat_addr][8*b +: 8] <= lat_din[8*b +: 8];
         end else begin
            sram_dout0 <= macro_mem[lat_addr];
         end
      end
   end

   // Reference: plain memory array plus queue of read results in accept order.
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] exp_q [$];
   int            pop_cycles [$];
   int            n_checks = 0;
   int            n_pass = 0;
   int            cyc = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endfunction

   function automatic void fail_now(string nm);
      n_checks++;
      $display("FAIL %s: got timeout/unexpected event expected normal completion", nm);
   endfunction

   function automatic void model_accept(logic we, logic [AW-1:0] a, logic [NM-1:0] m,
                                        logic [DW-1:0] d);
      if (we) begin
         for (int b = 0; b < NM; b++)
            if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
         exp_q.push_back(ref_mem[a]);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Handshake values at negedge are those seen by the next posedge.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         pop_cycles.push_back(cyc);
         if (exp_q.size() == 0) fail_now("unexpected_rsp");
         else chk("rsp_data", 64'(rsp_rdata), 64'(exp_q.pop_front()));
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [NM-1:0] m,
                        input logic [DW-1:0] d, output int waits);
      logic acc;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wmask = m;
      req_wdata = d;
      waits = 0;
      acc = 1'b0;
      while (!acc && waits < 200) begin
         acc = req_ready;
         tick(1);
         if (!acc) waits++;
      end
      req_valid = 1'b0;
      if (!acc) begin
         fail_now("accept_timeout");
      end else begin
         model_accept(we, a, m, d);
         chk("sram_ctl", 64'({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0}),
             64'({1'b0, !we, (we ? m : 4'h0), a, d}));
      end
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] init;
      logic [NM-1:0] mask;
      logic [DW-1:0] upd;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int w;
      int n_acc;
      logic acc;
      for (int i = 0; i < 256; i++) begin
         macro_mem[i] = '0;
         ref_mem[i]   = '0;
      end
      vecs[0] = '{addr: 8'h10, init: 32'h0000_0000, mask: 4'hF,    upd: 32'hDEAD_BEEF, exp: 32'hDEAD_BEEF};
      vecs[1] = '{addr: 8'h20, init: 32'h1122_3344, mask: 4'b0101, upd: 32'hAABB_CCDD, exp: 32'h11BB_33DD};
      vecs[2] = '{addr: 8'h30, init: 32'hCAFE_F00D, mask: 4'b1000, upd: 32'h1234_5678, exp: 32'h12FE_F00D};
      vecs[3] = '{addr: 8'hFF, init: 32'hFFFF_FFFF, mask: 4'b0000, upd: 32'h0000_0000, exp: 32'hFFFF_FFFF};
      vecs[4] = '{addr: 8'h00, init: 32'h0123_4567, mask: 4'b0011, upd: 32'h89AB_CDEF, exp: 32'h0123_CDEF};

      // Reset values
      tick(3);
      chk("reset_outs", 64'({req_ready, rsp_valid, busy, sram_csb0, sram_web0, sram_wmask0,
                             sram_addr0, sram_din0}),
          64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 32'h0}));
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", 64'(req_ready), 64'(1));

      // Table: full write, masked write, read next cycle; response exactly 2 cycles after accept
      rsp_ready_man = 1'b1;
      foreach (vecs[k]) begin
         issue(1'b1, vecs[k].addr, 4'hF, vecs[k].init, w);
         issue(1'b1, vecs[k].addr, vecs[k].mask, vecs[k].upd, w);
         issue(1'b0, vecs[k].addr, 4'h0, 32'h0, w);
         tick(1);
         chk("lat1_valid_csb", 64'({rsp_valid, sram_csb0}), 64'(2'b01));
         tick(1);
         chk("lat2_valid", 64'(rsp_valid), 64'(1));
         chk("vec_rdata", 64'(rsp_rdata), 64'(vecs[k].exp));
         tick(1);
         chk("vec_drained", 64'({rsp_valid, busy}), 64'(2'b00));
      end

      // Back-to-back reads of 0x00..0x07
      for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), 4'hF, 32'hA500_0000 + DW'(i * 32'h111), w);
      tick(2);
      pop_cycles.delete();
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, AW'(i), 4'h0, 32'h0, w);
         chk("b2b_no_wait", 64'(w), 64'(0));
      end
      tick(5);
      chk("b2b_rsp_count", 64'(pop_cycles.size()), 64'(8));
      if (pop_cycles.size() == 8) chk("b2b_consecutive", 64'(pop_cycles[7] - pop_cycles[0]), 64'(7));

      // Backpressure: 6 reads with rsp_ready low
      for (int i = 0; i < 6; i++) issue(1'b1, AW'(32'h40 + i), 4'hF, 32'h5A5A_0000 + DW'(i), w);
      tick(2);
      rsp_ready_man = 1'b0;
      n_acc = 0;
      req_valid = 1'b1;
      req_we = 1'b0;
      for (int c = 0; c < 10; c++) begin
         req_addr = AW'(32'h40 + n_acc);
         acc = req_ready;
         tick(1);
         if (acc) begin
            model_accept(1'b0, req_addr, 4'h0, 32'h0);
            n_acc++;
         end
      end
      chk("bp_accepted", 64'(n_acc), 64'(4));
      chk("bp_state", 64'({req_ready, rsp_valid, busy}), 64'(3'b011));
      rsp_ready_man = 1'b1;
      for (int c = 0; c < 30 && n_acc < 6; c++) begin
         req_addr = AW'(32'h40 + n_acc);
         acc = req_ready;
         tick(1);
         if (acc) begin
            model_accept(1'b0, req_addr, 4'h0, 32'h0);
            n_acc++;
         end
      end
      req_valid = 1'b0;
      chk("bp_rest_accepted", 64'(n_acc), 64'(6));
      tick(8);
      chk("bp_drain", 64'({exp_q.size() == 0, req_ready, busy}), 64'(3'b110));

      // Reset with two reads in flight and one FIFO entry
      rsp_ready_man = 1'b0;
      issue(1'b0, 8'h10, 4'h0, 32'h0, w);
      issue(1'b0, 8'h20, 4'h0, 32'h0, w);
      issue(1'b0, 8'h30, 4'h0, 32'h0, w);
      chk("pre_reset_busy", 64'({rsp_valid, busy}), 64'(2'b11));
      rst_n = 1'b0;
      tick(1);
      chk("mid_reset", 64'({rsp_valid, busy, req_ready, sram_csb0}), 64'(4'b0001));
      exp_q.delete();
      rst_n = 1'b1;
      #1;
      chk("post_reset_ready", 64'(req_ready), 64'(1));
      rsp_ready_man = 1'b1;
      tick(6);
      chk("no_stale", 64'({rsp_valid, busy}), 64'(2'b00));

      // Random mixed traffic with random rsp_ready
      rnd_rdy = 1'b1;
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 3) == 0) tick(1);
         else issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                    NM'($urandom_range(0, 15)), DW'($urandom), w);
      end
      rnd_rdy = 1'b0;
      rsp_ready_man = 1'b1;
      for (int c = 0; c < 50 && (exp_q.size() != 0 || busy); c++) tick(1);
      chk("rand_drain", 64'({exp_q.size() == 0, busy}), 64'(2'b10));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got time limit expected completion");
      $fatal(1, "watchdog");
   end

endmodule
